// File: rtl/alu_pkg.sv
// Shared types for the ALU request scheduler: ALU op codes, scheduler states
// and the op-code legality check.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b1000,
    OP_SLL  = 4'b0001,
    OP_SLT  = 4'b0010,
    OP_SLTU = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SRA  = 4'b1101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  function automatic logic is_legal_op(alu_op_e op);
    case (op)
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
      OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_req_scheduler_if.sv
// Requester-side bus of the ALU scheduler. master = requesters, slave = scheduler.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready
// are both high; valid, once raised, is held with stable payload until that edge.
interface alu_req_scheduler_if #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*XLEN-1:0] req_operand1;
  logic [NUM_REQ*XLEN-1:0] req_operand2;
  logic [NUM_REQ*4-1:0]    req_operation;
  logic [NUM_REQ-1:0]      resp_valid;
  logic [NUM_REQ-1:0]      resp_ready;
  logic [XLEN-1:0]         resp_result;
  logic                    resp_err;

  modport master (
    output req_valid, req_operand1, req_operand2, req_operation, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_err
  );

  modport slave (
    input  req_valid, req_operand1, req_operand2, req_operation, resp_ready,
    output req_ready, resp_valid, resp_result, resp_err
  );
endinterface

// File: rtl/alu.sv
// Combinational RV32I ALU; shift amount comes from operand2[4:0].
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic [3:0]      operation,
  output logic [XLEN-1:0] result
);
  logic [4:0] shamt;
  assign shamt = operand2[4:0];

  always_comb begin
    result = '0;
    case (alu_op_e'(operation))
      OP_ADD:  result = operand1 + operand2;
      OP_SUB:  result = operand1 - operand2;
      OP_SLL:  result = operand1 << shamt;
      OP_SLT:  result = {{(XLEN-1){1'b0}}, $signed(operand1) < $signed(operand2)};
      OP_SLTU: result = {{(XLEN-1){1'b0}}, operand1 < operand2};
      OP_XOR:  result = operand1 ^ operand2;
      OP_SRL:  result = operand1 >> shamt;
      OP_SRA:  result = XLEN'($signed(operand1) >>> shamt);
      OP_OR:   result = operand1 | operand2;
      OP_AND:  result = operand1 & operand2;
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/alu_rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or after ptr, wrapping.
module alu_rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);
  logic [IW-1:0] pos;

  // Scan from the farthest candidate back to ptr so the nearest valid one wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = IW'((int'(ptr) + k) % NUM_REQ);
      if (req[pos]) begin
        idx = pos;
        any = 1'b1;
      end
    end
    if (any) grant[idx] = 1'b1;
  end
endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU between NUM_REQ requesters: round-robin grant, registered
// operands and result, illegal-op flagging and a wrapping completed-op counter.
module alu_req_scheduler
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 32,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_req_scheduler_if.slave   bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count,
  output sched_state_e         state_dbg
);
  sched_state_e       state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      g_q;
  logic [XLEN-1:0]    op1_q;
  logic [XLEN-1:0]    op2_q;
  logic [3:0]         op_q;
  logic [XLEN-1:0]    result_q;
  logic               err_q;
  logic [NUM_REQ-1:0] resp_valid_q;

  logic [NUM_REQ-1:0] win_grant;
  logic [IW-1:0]      win_idx;
  logic               win_any;
  logic [XLEN-1:0]    alu_result;
  logic               op_legal;

  alu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  alu #(.XLEN(XLEN)) u_alu (
    .operand1  (op1_q),
    .operand2  (op2_q),
    .operation (op_q),
    .result    (alu_result)
  );

  assign op_legal        = is_legal_op(alu_op_e'(op_q));
  assign bus.req_ready   = (state == IDLE) ? win_grant : '0;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = result_q;
  assign bus.resp_err    = err_q;
  assign busy            = (state != IDLE);
  assign state_dbg       = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      g_q          <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      op_q         <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= '0;
      op_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_any) begin
            op1_q <= bus.req_operand1[win_idx*XLEN +: XLEN];
            op2_q <= bus.req_operand2[win_idx*XLEN +: XLEN];
            op_q  <= bus.req_operation[win_idx*4 +: 4];
            g_q   <= win_idx;
            state <= EXEC;
          end
        end
        EXEC: begin
          result_q     <= op_legal ? alu_result : '0;
          err_q        <= ~op_legal;
          resp_valid_q <= NUM_REQ'(1) << g_q;
          state        <= RESP;
        end
        RESP: begin
          // Only the granted requester's resp_ready can complete the op.
          if (bus.resp_ready[g_q]) begin
            resp_valid_q <= '0;
            op_count     <= op_count + 1'b1;
            rr_ptr       <= (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: transaction-level model checked every cycle plus
// directed scenarios with hand-computed results.
module tb_alu_req_scheduler;
  import alu_pkg::*;

  localparam int N     = 2;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  sched_state_e     state_dbg;

  int total = 0;
  int bad   = 0;

  alu_req_scheduler_if #(.NUM_REQ(N), .XLEN(XLEN)) bus ();

  alu_req_scheduler #(.NUM_REQ(N), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .op_count  (op_count),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [XLEN:0] ref_op(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    int unsigned sh;
    sh = b[4:0];
    case (op)
      4'b0000: return {1'b0, a + b};
      4'b1000: return {1'b0, a - b};
      4'b0001: return {1'b0, 32'(a << sh)};
      4'b0010: return {1'b0, 31'd0, $signed(a) < $signed(b)};
      4'b0011: return {1'b0, 31'd0, a < b};
      4'b0100: return {1'b0, a ^ b};
      4'b0101: return {1'b0, 32'(a >> sh)};
      4'b1101: return {1'b0, 32'($signed(a) >>> sh)};
      4'b0110: return {1'b0, a | b};
      4'b0111: return {1'b0, a & b};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // Scoreboard: {err, result} of the one op in flight.
  logic [XLEN:0]    exp_q[$];
  logic [CNT_W-1:0] m_cnt;
  int               m_ptr, m_age, m_g;
  bit               m_pend, m_rst_seen;

  initial begin
    logic [N-1:0]  exp_ready, exp_rv;
    sched_state_e  exp_state;
    m_ptr = 0; m_cnt = '0; m_pend = 0; m_age = 0; m_g = 0; m_rst_seen = 1;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_ready = '0;
      if (!m_pend) begin
        for (int k = 0; k < N; k++) begin
          if (bus.req_valid[(m_ptr + k) % N]) begin
            exp_ready[(m_ptr + k) % N] = 1'b1;
            break;
          end
        end
      end
      exp_rv    = (m_pend && m_age >= 2) ? N'(1) << m_g : '0;
      exp_state = !m_pend ? IDLE : (m_age == 1 ? EXEC : RESP);
      chk("m_req_ready", bus.req_ready, exp_ready);
      chk("m_resp_valid", bus.resp_valid, exp_rv);
      chk("m_busy", busy, m_pend);
      chk("m_op_count", op_count, m_cnt);
      chk("m_state", state_dbg, exp_state);
      if (exp_rv != 0 && exp_q.size() > 0) begin
        chk("m_resp_result", bus.resp_result, exp_q[0][XLEN-1:0]);
        chk("m_resp_err", bus.resp_err, exp_q[0][XLEN]);
      end
      if (m_rst_seen) begin
        chk("m_rst_result", bus.resp_result, 0);
        chk("m_rst_err", bus.resp_err, 0);
      end
      // Predict what the coming edge does.
      if (rst) begin
        m_pend = 0; m_ptr = 0; m_cnt = '0; m_rst_seen = 1;
        exp_q.delete();
      end else begin
        m_rst_seen = 0;
        if (!m_pend && exp_ready != 0) begin
          for (int i = 0; i < N; i++) if (exp_ready[i]) m_g = i;
          exp_q.push_back(ref_op(bus.req_operation[m_g*4 +: 4],
                                 bus.req_operand1[m_g*XLEN +: XLEN],
                                 bus.req_operand2[m_g*XLEN +: XLEN]));
          m_pend = 1;
          m_age  = 1;
        end else if (m_pend) begin
          if (m_age >= 2 && bus.resp_ready[m_g]) begin
            void'(exp_q.pop_front());
            m_pend = 0;
            m_cnt++;
            m_ptr = (m_g + 1) % N;
          end else begin
            m_age++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(int i, logic [31:0] a, logic [31:0] b, logic [3:0] op);
    bus.req_valid[i]               = 1'b1;
    bus.req_operand1[i*XLEN +: XLEN] = a;
    bus.req_operand2[i*XLEN +: XLEN] = b;
    bus.req_operation[i*4 +: 4]    = op;
  endtask

  // Called just after a rising edge; drops valid of whoever got the grant.
  task automatic wait_grant(logic [N-1:0] exp, string name);
    int n;
    logic [N-1:0] got;
    n = 0;
    @(negedge clk);
    while (bus.req_ready == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    got = bus.req_ready;
    chk(name, got, exp);
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~got;
  endtask

  task automatic wait_resp(int i, logic [31:0] exp_res, logic exp_err, string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.resp_valid[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, bus.resp_valid[i], 1);
    chk({name, "_result"}, bus.resp_result, exp_res);
    chk({name, "_err"}, bus.resp_err, exp_err);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    rst               = 1'b1;
    bus.req_valid     = '0;
    bus.req_operand1  = '0;
    bus.req_operand2  = '0;
    bus.req_operation = '0;
    bus.resp_ready    = '1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_count", op_count, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    @(posedge clk);
    #1;

    // 1: single ADD, exact latency
    set_req(0, 32'h10, 32'h20, 4'b0000);
    wait_grant(2'b01, "t1_grant");
    @(negedge clk);
    chk("t1_rv_cycle1", bus.resp_valid, 0);
    wait_resp(0, 32'h30, 1'b0, "t1");
    @(negedge clk);
    chk("t1_count", op_count, 1);
    @(posedge clk);
    #1;

    // 2: serve req1 once to bring the pointer back to 0, then contention
    set_req(1, 32'h0F0, 32'h00F, 4'b0110);
    wait_grant(2'b10, "t2_pre_grant");
    wait_resp(1, 32'hFF, 1'b0, "t2_pre");
    set_req(0, 32'h30, 32'h10, 4'b1000);
    set_req(1, 32'hFF00, 32'h0F0F, 4'b0111);
    wait_grant(2'b01, "t2_grant0");
    wait_resp(0, 32'h20, 1'b0, "t2_r0");
    set_req(0, 32'h3, 32'h7, 4'b0011);
    wait_grant(2'b10, "t2_grant1");
    wait_resp(1, 32'h0F00, 1'b0, "t2_r1");
    wait_grant(2'b01, "t2_grant0b");
    wait_resp(0, 32'h1, 1'b0, "t2_r0b");

    // 3: backpressure on SRA while req1 waits
    bus.resp_ready[0] = 1'b0;
    set_req(0, 32'hF000_0000, 32'h4, 4'b1101);
    wait_grant(2'b01, "t3_grant");
    set_req(1, 32'hFFFF_FFFF, 32'h1, 4'b0010);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.resp_valid[0] && n < 20) begin
        @(negedge clk);
        n++;
      end
      for (int j = 0; j < 5; j++) begin
        if (j > 0) @(negedge clk);
        chk("t3_hold_valid", bus.resp_valid, 2'b01);
        chk("t3_hold_result", bus.resp_result, 32'hFF00_0000);
        chk("t3_hold_ready", bus.req_ready, 0);
        chk("t3_hold_busy", busy, 1);
        chk("t3_hold_count", op_count, 5);
      end
    end
    @(posedge clk);
    #1;
    bus.resp_ready[0] = 1'b1;
    @(negedge clk);
    chk("t3_pre_hs_count", op_count, 5);
    @(negedge clk);
    chk("t3_post_hs_count", op_count, 6);
    chk("t3_post_hs_ready", bus.req_ready, 2'b10);
    @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b0;
    wait_resp(1, 32'h1, 1'b0, "t3_slt");

    // 4: illegal op
    set_req(0, 32'h5, 32'h7, 4'b1111);
    wait_grant(2'b01, "t4_grant");
    wait_resp(0, 32'h0, 1'b1, "t4");
    @(negedge clk);
    chk("t4_count", op_count, 8);
    @(posedge clk);
    #1;

    // 5: reset while the SLL is in EXEC
    set_req(0, 32'h1, 32'h4, 4'b0001);
    wait_grant(2'b01, "t5_grant");
    pulse_reset();
    @(negedge clk);
    chk("t5_busy", busy, 0);
    chk("t5_count", op_count, 0);
    chk("t5_resp_valid", bus.resp_valid, 0);
    chk("t5_result", bus.resp_result, 0);
    chk("t5_err", bus.resp_err, 0);
    chk("t5_ready", bus.req_ready, 0);
    chk("t5_state", state_dbg, IDLE);
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_resp", bus.resp_valid, 0);
    end
    @(posedge clk);
    #1;
    set_req(0, 32'hFFFF, 32'h00FF, 4'b0100);
    wait_grant(2'b01, "t5_xor_grant");
    wait_resp(0, 32'hFF00, 1'b0, "t5_xor");

    // 6: 16 back-to-back ops wrap the 4-bit counter
    pulse_reset();
    for (int k = 0; k < 16; k++) begin
      set_req(k % 2, 32'(k), 32'(k), 4'b0000);
      wait_grant(N'(1) << (k % 2), "t6_grant");
      wait_resp(k % 2, 32'(2 * k), 1'b0, "t6");
    end
    @(negedge clk);
    chk("t6_wrap", op_count, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
